// File: rtl/melody_pkg.sv
// Shared types, constants and song ROM contents for the melody sequencer.
package melody_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PLAY,
    ST_GAP,
    ST_DONE
  } state_e;

  localparam logic [3:0] NOTE_REST = 4'd0;
  localparam logic [3:0] NOTE_END  = 4'd15;

  localparam logic [1:0] OCT_NORM = 2'b00;
  localparam logic [1:0] OCT_UP   = 2'b01;
  localparam logic [1:0] OCT_DOWN = 2'b10;

  localparam int unsigned NOTE_W = 4;
  localparam int unsigned OCT_W  = 2;
  localparam int unsigned DUR_W  = 3;

  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [OCT_W-1:0]  oct;
    logic [DUR_W-1:0]  dur;
  } entry_t;

  localparam entry_t TEST_SONG [4] = '{
    '{note: 4'd1,     oct: OCT_NORM, dur: 3'd0},
    '{note: 4'd5,     oct: OCT_UP,   dur: 3'd1},
    '{note: NOTE_REST, oct: OCT_NORM, dur: 3'd0},
    '{note: NOTE_END, oct: OCT_NORM, dur: 3'd0}
  };

  // Song 0 is the short test song, song 1 fills every slot with no END,
  // song 2 mixes rests/long notes, anything else ends immediately.
  function automatic entry_t song_entry(input int unsigned song, input int unsigned idx);
    entry_t e;
    e = '{note: NOTE_END, oct: OCT_NORM, dur: 3'd0};
    case (song)
      0: if (idx < 4) e = TEST_SONG[2'(idx)];
      1: e = '{note: 4'(idx % 7 + 1), oct: 2'(idx % 4), dur: 3'(idx % 3)};
      2: begin
        case (idx)
          0: e = '{note: 4'd9,  oct: OCT_UP,   dur: 3'd0};
          1: e = '{note: 4'd3,  oct: OCT_DOWN, dur: 3'd7};
          2: e = '{note: 4'd14, oct: 2'b11,    dur: 3'd0};
          3: e = '{note: 4'd7,  oct: 2'b11,    dur: 3'd1};
          default: ;
        endcase
      end
      default: ;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/melody_rom.sv
// Synchronous song ROM, one-cycle read latency, addressed by {song, index}.
module melody_rom
  import melody_pkg::*;
#(
  parameter int unsigned NUM_SONGS  = 4,
  parameter int unsigned SONG_DEPTH = 32
) (
  input  logic                                     clk,
  input  logic [$clog2(NUM_SONGS*SONG_DEPTH)-1:0]  addr,
  output entry_t                                   data
);

  localparam int unsigned AW = $clog2(NUM_SONGS * SONG_DEPTH);
  localparam int unsigned IW = $clog2(SONG_DEPTH);

  always_ff @(posedge clk) begin
    data <= song_entry(32'(addr[AW-1:IW]), 32'(addr[IW-1:0]));
  end

endmodule

// File: rtl/melody_sequencer.sv
// Steps through a song ROM, driving note/octave for each entry's duration
// followed by a silent articulation gap; start/stop/loop control.
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int unsigned TICKS_PER_BEAT = 25_000_000,
  parameter int unsigned GAP_TICKS      = 2_500_000,
  parameter int unsigned SONG_DEPTH     = 32,
  parameter int unsigned NUM_SONGS      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          stop,
  input  logic                          loop,
  input  logic [$clog2(NUM_SONGS)-1:0]  song_sel,
  output logic [3:0]                    note,
  output logic                          octave_up,
  output logic                          octave_down,
  output logic                          playing,
  output logic                          done,
  output logic [$clog2(SONG_DEPTH)-1:0] index
);

  localparam int unsigned SW = $clog2(NUM_SONGS);
  localparam int unsigned IW = $clog2(SONG_DEPTH);
  localparam int unsigned DW = $clog2(8 * TICKS_PER_BEAT);
  localparam int unsigned GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

  state_e         state_q, state_d;
  logic [SW-1:0]  song_q, song_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [DW-1:0]  dur_q, dur_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic           advance;
  entry_t         rom_data;
  logic           is_tone;

  logic [3:0]     note_d;
  logic           up_d, down_d, playing_d, done_d;

  // Address is taken from next-state values so the entry is valid during LOAD.
  melody_rom #(
    .NUM_SONGS  (NUM_SONGS),
    .SONG_DEPTH (SONG_DEPTH)
  ) u_rom (
    .clk  (clk),
    .addr ({song_d, idx_d}),
    .data (rom_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      song_q      <= '0;
      idx_q       <= '0;
      dur_q       <= '0;
      gap_q       <= '0;
      note        <= '0;
      octave_up   <= 1'b0;
      octave_down <= 1'b0;
      playing     <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      song_q      <= song_d;
      idx_q       <= idx_d;
      dur_q       <= dur_d;
      gap_q       <= gap_d;
      note        <= note_d;
      octave_up   <= up_d;
      octave_down <= down_d;
      playing     <= playing_d;
      done        <= done_d;
    end
  end

  assign index = idx_q;

  always_comb begin
    state_d = state_q;
    song_d  = song_q;
    idx_d   = idx_q;
    dur_d   = dur_q;
    gap_d   = gap_q;
    advance = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d = ST_LOAD;
          song_d  = song_sel;
          idx_d   = '0;
        end
      end
      ST_LOAD: begin
        if (rom_data.note == NOTE_END) begin
          if (loop) idx_d = '0;
          else      state_d = ST_DONE;
        end else begin
          state_d = ST_PLAY;
          dur_d   = DW'((32'(rom_data.dur) + 32'd1) * TICKS_PER_BEAT - 32'd1);
        end
      end
      ST_PLAY: begin
        if (dur_q == '0) begin
          if (GAP_TICKS == 0) begin
            advance = 1'b1;
          end else begin
            state_d = ST_GAP;
            gap_d   = GW'(GAP_TICKS - 1);
          end
        end else begin
          dur_d = dur_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_q == '0) advance = 1'b1;
        else             gap_d = gap_q - 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Running off the last slot behaves exactly like reading END.
    if (advance) begin
      if (idx_q == IW'(SONG_DEPTH - 1)) begin
        if (loop) begin
          state_d = ST_LOAD;
          idx_d   = '0;
        end else begin
          state_d = ST_DONE;
        end
      end else begin
        state_d = ST_LOAD;
        idx_d   = idx_q + 1'b1;
      end
    end

    if (stop && state_q != ST_IDLE) state_d = ST_IDLE;
    if (state_d == ST_IDLE) idx_d = '0;
  end

  assign is_tone = (rom_data.note != NOTE_REST) && (rom_data.note < 4'd8);

  // Outputs are computed for the upcoming state and registered.
  always_comb begin
    note_d    = '0;
    up_d      = 1'b0;
    down_d    = 1'b0;
    playing_d = 1'b0;
    done_d    = 1'b0;
    case (state_d)
      ST_LOAD, ST_GAP: playing_d = 1'b1;
      ST_PLAY: begin
        playing_d = 1'b1;
        if (state_q == ST_LOAD) begin
          note_d = is_tone ? rom_data.note : NOTE_REST;
          up_d   = is_tone && (rom_data.oct == OCT_UP);
          down_d = is_tone && (rom_data.oct == OCT_DOWN);
        end else begin
          note_d = note;
          up_d   = octave_up;
          down_d = octave_down;
        end
      end
      ST_DONE: done_d = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// Self-checking bench: per-scenario expected output timeline built from the
// song contents and timing rules, compared every cycle against the DUT.
module tb_melody_sequencer;

  localparam int TPB   = 4;
  localparam int GAP   = 1;
  localparam int DEPTH = 32;
  localparam int NS    = 4;
  localparam int CAP   = 700;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       loop = 1'b0;
  logic [1:0] song_sel = '0;
  logic [3:0] note;
  logic       octave_up, octave_down, playing, done;
  logic [4:0] index;

  int checks = 0;
  int errors = 0;
  logic [15:0] tl[$];

  melody_sequencer #(
    .TICKS_PER_BEAT (TPB),
    .GAP_TICKS      (GAP),
    .SONG_DEPTH     (DEPTH),
    .NUM_SONGS      (NS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .loop        (loop),
    .song_sel    (song_sel),
    .note        (note),
    .octave_up   (octave_up),
    .octave_down (octave_down),
    .playing     (playing),
    .done        (done),
    .index       (index)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h (note[12:9] up[8] down[7] play[6] done[5] idx[4:0])",
               tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mk(input int n, input bit u, input bit d,
                                     input bit p, input bit dn, input int i);
    return {3'b0, 4'(n), u, d, p, dn, 5'(i)};
  endfunction

  // Song contents as listed for the ROM: returns note, octave code, duration.
  task automatic ref_entry(input int song, input int idx, output int n, output int o, output int d);
    n = 15; o = 0; d = 0;
    case (song)
      0: case (idx)
           0: begin n = 1; o = 0; d = 0; end
           1: begin n = 5; o = 1; d = 1; end
           2: begin n = 0; o = 0; d = 0; end
           default: ;
         endcase
      1: begin n = idx % 7 + 1; o = idx % 4; d = idx % 3; end
      2: case (idx)
           0: begin n = 9;  o = 1; d = 0; end
           1: begin n = 3;  o = 2; d = 7; end
           2: begin n = 14; o = 3; d = 0; end
           3: begin n = 7;  o = 3; d = 1; end
           default: ;
         endcase
      default: ;
    endcase
  endtask

  // Expected outputs per cycle; entry 0 is the idle cycle in which start is applied.
  task automatic build(input int song, input bit lp, input bit hold);
    int i, n, o, d;
    bit fin, tone;
    tl.delete();
    tl.push_back('0);
    while (tl.size() < CAP) begin
      i = 0;
      fin = 0;
      while (!fin && tl.size() < CAP) begin
        ref_entry(song, i, n, o, d);
        tl.push_back(mk(0, 0, 0, 1, 0, i));
        if (n == 15) begin
          if (lp) i = 0;
          else begin
            tl.push_back(mk(0, 0, 0, 0, 1, i));
            fin = 1;
          end
        end else begin
          tone = (n >= 1 && n <= 7);
          for (int k = 0; k < (d + 1) * TPB; k++)
            tl.push_back(mk(tone ? n : 0, tone && o == 1, tone && o == 2, 1, 0, i));
          for (int k = 0; k < GAP; k++)
            tl.push_back(mk(0, 0, 0, 1, 0, i));
          if (i == DEPTH - 1) begin
            if (lp) i = 0;
            else begin
              tl.push_back(mk(0, 0, 0, 0, 1, i));
              fin = 1;
            end
          end else begin
            i++;
          end
        end
      end
      if (!hold) break;
      tl.push_back('0);
    end
  endtask

  // abort < 0: none; otherwise stop (held) or a one-cycle reset at that cycle.
  task automatic run(input string name, input int song, input bit lp, input bit hold,
                     input int abort, input bit abort_rst, input int busy);
    int ncyc;
    logic [15:0] exp, obs;
    build(song, lp, hold);
    ncyc = tl.size() + 2;
    if (abort >= 0 && abort + 4 < ncyc) ncyc = abort + 4;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      #1;
      exp = (c < tl.size() && (abort < 0 || c <= abort)) ? tl[c] : '0;
      obs = {3'b0, note, octave_up, octave_down, playing, done, index};
      chk($sformatf("%s c%0d", name, c), obs, exp);
      start    = (c == 0 || hold || c == busy) && !(abort >= 0 && c > abort);
      stop     = !abort_rst && abort >= 0 && c >= abort;
      rst      = abort_rst && c == abort;
      loop     = lp;
      song_sel = (c == 0 || hold) ? 2'(song) : 2'($urandom);
    end
    start = 1'b0;
    stop  = 1'b0;
    rst   = 1'b0;
  endtask

  initial begin
    int song, abort, busy;
    bit lp, hold, arst;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset", {3'b0, note, octave_up, octave_down, playing, done, index}, 16'h0000);

    run("basic",     0, 0, 0, -1, 0, -1);
    run("stop",      0, 0, 0, 10, 0, -1);
    run("loop",      0, 1, 0, 40, 0, -1);
    run("startstop", 0, 0, 0,  0, 0, -1);
    run("busy",      0, 0, 0, -1, 0,  9);
    run("reset12",   0, 0, 0, 12, 1, -1);
    run("fresh",     0, 0, 0, -1, 0, -1);
    run("wrap",      1, 0, 0, -1, 0, -1);
    run("wraploop",  1, 1, 0, 360, 0, -1);
    run("song2",     2, 0, 0, -1, 0, -1);
    run("endfirst",  3, 0, 0, -1, 0, -1);
    run("hold",      0, 0, 1, 60, 0, -1);

    for (int r = 0; r < 25; r++) begin
      song = int'($urandom_range(0, 3));
      lp   = ($urandom % 3) == 0;
      hold = ($urandom % 4) == 0;
      arst = ($urandom % 2) == 1;
      build(song, lp, hold);
      if (lp || hold)              abort = int'($urandom_range(1, 150));
      else if ($urandom % 2 == 1)  abort = int'($urandom_range(0, tl.size() + 1));
      else                         abort = -1;
      busy = int'($urandom_range(1, tl.size() - 1));
      if (tl[busy][6:5] == 2'b00) busy = -1;
      run($sformatf("rnd%0d_s%0d", r, song), song, lp, hold, abort, arst, busy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
